// File: rtl/anc_pkg.sv
// Shared constants and state type for the ANC I2S transmitter.
package anc_pkg;
    localparam int SAMPLE_W        = 16;
    localparam int SLOTS_PER_CH    = 32;
    localparam int SLOTS_PER_FRAME = 2 * SLOTS_PER_CH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;
endpackage

// File: rtl/anc_i2s_tx_clk_gen.sv
// BCLK divider and slot counter; frozen at zero until run_in rises.
module i2s_clk_gen #(
    parameter int HALF_DIV = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       run_in,
    output logic       bclk,
    output logic       fall_strobe,
    output logic [5:0] slot
);
    localparam int DW = $clog2(HALF_DIV);

    logic [DW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic [5:0]    slot_q, slot_d;
    logic          half_done;

    always_comb begin
        half_done = run_in && (div_q == DW'(HALF_DIV - 1));
        div_d     = div_q;
        bclk_d    = bclk_q;
        slot_d    = slot_q;
        if (run_in) begin
            div_d = half_done ? '0 : div_q + 1'b1;
            if (half_done) begin
                bclk_d = ~bclk_q;
                // A slot ends on each falling edge; the 6-bit counter wraps 63 -> 0.
                if (bclk_q) begin
                    slot_d = slot_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
            slot_q <= 6'd0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
            slot_q <= slot_d;
        end
    end

    assign bclk        = bclk_q;
    assign fall_strobe = half_done && bclk_q;
    assign slot        = slot_q;
endmodule

// File: rtl/anc_i2s_tx.sv
// Mono I2S transmitter for the ANC anti-noise path: holds the latest FIR
// sample, latches it at each frame start and shifts it out on both channels.
module anc_i2s_tx
    import anc_pkg::*;
#(
    parameter int BCLK_HALF_DIV = 16,
    parameter int SAMPLE_W      = anc_pkg::SAMPLE_W
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       ready_in,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       mute_in,
    output logic                       bclk_out,
    output logic                       lrclk_out,
    output logic                       sdata_out,
    output logic                       frame_start_out,
    output logic                       underrun_out,
    output logic                       overrun_out
);
    tx_state_e           state_q, state_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic [SAMPLE_W-1:0] active_q, active_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic                sdata_q, sdata_d;
    logic                lrclk_q, lrclk_d;
    logic                frame_start_q, frame_start_d;
    logic                underrun_q, underrun_d;
    logic                overrun_q, overrun_d;

    logic       run;
    logic       bclk;
    logic       fall;
    logic [5:0] slot;
    logic [5:0] slot_next;
    logic [4:0] ch_slot;
    logic       start_run;
    logic       frame_start;

    assign run = (state_q == ST_RUN);

    i2s_clk_gen #(
        .HALF_DIV(BCLK_HALF_DIV)
    ) u_clk_gen (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .run_in     (run),
        .bclk       (bclk),
        .fall_strobe(fall),
        .slot       (slot)
    );

    always_comb begin
        slot_next   = slot + 6'd1;
        ch_slot     = slot_next[4:0];
        start_run   = (state_q == ST_IDLE) && hold_valid_q;
        frame_start = start_run || (fall && (slot == 6'(SLOTS_PER_FRAME - 1)));

        state_d       = start_run ? ST_RUN : state_q;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        active_d      = active_q;
        shift_d       = shift_q;
        sdata_d       = sdata_q;
        lrclk_d       = lrclk_q;
        frame_start_d = frame_start;
        underrun_d    = frame_start && !hold_valid_q;
        overrun_d     = ready_in && hold_valid_q && !frame_start;

        if (frame_start) begin
            hold_valid_d = 1'b0;
            if (mute_in) begin
                active_d = '0;
            end else if (hold_valid_q) begin
                active_d = hold_q;
            end
            shift_d = active_d;
            sdata_d = 1'b0;
            lrclk_d = 1'b0;
        end else if (fall) begin
            lrclk_d = (int'(slot_next) >= SLOTS_PER_CH);
            if (ch_slot == 5'd0) begin
                // Right channel repeats the same word, so reload the shifter.
                shift_d = active_q;
                sdata_d = 1'b0;
            end else if (int'(ch_slot) <= SAMPLE_W) begin
                sdata_d = shift_q[SAMPLE_W-1];
                shift_d = shift_q << 1;
            end else begin
                sdata_d = 1'b0;
            end
        end

        // Applied after the frame-start transfer so a coincident sample survives.
        if (ready_in) begin
            hold_d       = sample_in;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q       <= ST_IDLE;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            active_q      <= '0;
            shift_q       <= '0;
            sdata_q       <= 1'b0;
            lrclk_q       <= 1'b1;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            active_q      <= active_d;
            shift_q       <= shift_d;
            sdata_q       <= sdata_d;
            lrclk_q       <= lrclk_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bclk_out        = bclk;
    assign lrclk_out       = lrclk_q;
    assign sdata_out       = sdata_q;
    assign frame_start_out = frame_start_q;
    assign underrun_out    = underrun_q;
    assign overrun_out     = overrun_q;
endmodule

// File: tb/tb_anc_i2s_tx.sv
// Bench for anc_i2s_tx: directed frame captures plus randomized traffic against
// a time-arithmetic model of the I2S output.
module tb_anc_i2s_tx;
    localparam int H     = 2;
    localparam int FRAME = 128 * H;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic [15:0] sample;
    logic        mute;
    logic        bclk_out, lrclk_out, sdata_out, frame_start_out, underrun_out, overrun_out;

    int total = 0;
    int bad   = 0;

    anc_i2s_tx #(
        .BCLK_HALF_DIV(H),
        .SAMPLE_W     (16)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .ready_in       (ready),
        .sample_in      (sample),
        .mute_in        (mute),
        .bclk_out       (bclk_out),
        .lrclk_out      (lrclk_out),
        .sdata_out      (sdata_out),
        .frame_start_out(frame_start_out),
        .underrun_out   (underrun_out),
        .overrun_out    (overrun_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [15:0] w);
        return {1'b0, w, 15'd0, 1'b0, w, 15'd0};
    endfunction

    // Model: output is a pure function of cycles since RUN entry and the frame word.
    bit          m_valid = 0;
    bit          m_run   = 0;
    int          m_t     = 0;
    bit          m_hv    = 0;
    logic [15:0] m_hold  = '0;
    logic [15:0] m_word  = '0;
    bit          e_bclk = 0, e_lr = 1, e_sd = 0, e_fs = 0, e_ur = 0, e_ov = 0;

    initial begin
        forever begin
            bit fs;
            int sl, cs;
            @(posedge clk);
            if (!rst_n) begin
                m_valid = 1; m_run = 0; m_t = 0; m_hv = 0; m_hold = '0; m_word = '0;
                e_bclk = 0; e_lr = 1; e_sd = 0; e_fs = 0; e_ur = 0; e_ov = 0;
            end else if (m_valid) begin
                fs = (!m_run && m_hv) || (m_run && ((m_t + 1) % FRAME == 0));
                if (!m_run && m_hv) begin
                    m_run = 1;
                    m_t   = 0;
                end else if (m_run) begin
                    m_t++;
                end
                e_fs = fs;
                e_ur = fs && !m_hv;
                e_ov = ready && m_hv && !fs;
                if (fs) begin
                    m_word = mute ? 16'h0 : (m_hv ? m_hold : m_word);
                    m_hv   = 0;
                end
                if (ready) begin
                    m_hold = sample;
                    m_hv   = 1;
                end
                if (m_run) begin
                    sl     = (m_t / (2 * H)) % 64;
                    cs     = sl % 32;
                    e_bclk = ((m_t / H) % 2) == 1;
                    e_lr   = sl >= 32;
                    e_sd   = (cs >= 1 && cs <= 16) ? m_word[16 - cs] : 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("bclk",        64'(bclk_out),        64'(e_bclk));
                chk("lrclk",       64'(lrclk_out),       64'(e_lr));
                chk("sdata",       64'(sdata_out),       64'(e_sd));
                chk("frame_start", 64'(frame_start_out), 64'(e_fs));
                chk("underrun",    64'(underrun_out),    64'(e_ur));
                chk("overrun",     64'(overrun_out),     64'(e_ov));
            end
        end
    end

    // Waits for a frame start, records one bit per slot, and injects stimulus mid-frame.
    task automatic capture(input logic [15:0] v1, input bit g1, input logic [15:0] v2, input bit g2,
                           input int mv, output logic [63:0] bits, output int ur, output int ov,
                           output int lat);
        bits = '0; ur = 0; ov = 0; lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!frame_start_out && lat < 2000);
        if (!frame_start_out) begin
            total++; bad++;
            $display("FAIL frame_wait: no frame_start after %0d cycles, want one", lat);
            return;
        end
        ur = int'(underrun_out);
        for (int idx = 0; idx < FRAME; idx++) begin
            if (idx > 0) @(negedge clk);
            if (idx % (2 * H) == 0) bits[63 - idx / (2 * H)] = sdata_out;
            ov += int'(overrun_out);
            if (idx == 40 && g1) begin ready = 1; sample = v1; end
            if (idx == 41) ready = 0;
            if (idx == 48 && g2) begin ready = 1; sample = v2; end
            if (idx == 49) ready = 0;
            if (idx == 80 && mv >= 0) mute = mv[0];
        end
        $display("frame: lat=%0d bits=%h underrun=%0d overrun=%0d", lat, bits, ur, ov);
    endtask

    initial begin
        logic [63:0] bits;
        int ur, ov, lat, edges, rst_cnt;
        rst_n = 0; ready = 0; sample = '0; mute = 0;
        repeat (4) @(negedge clk);
        chk("rst_bclk",  64'(bclk_out),        64'd0);
        chk("rst_lrclk", 64'(lrclk_out),       64'd1);
        chk("rst_sdata", 64'(sdata_out),       64'd0);
        chk("rst_fs",    64'(frame_start_out), 64'd0);
        rst_n = 1;
        repeat (5) @(negedge clk);
        chk("idle_lrclk", 64'(lrclk_out), 64'd1);

        ready = 1; sample = 16'hA5C3;
        @(negedge clk);
        ready = 0;
        capture(16'h1234, 1, 16'h0, 0, -1, bits, ur, ov, lat);
        chk("run_entry_lat", 64'(lat), 64'd1);
        chk("f1_bits", bits, mk(16'hA5C3));
        chk("f1_ur", 64'(ur), 64'd0);

        capture(16'h0, 0, 16'h0, 0, -1, bits, ur, ov, lat);
        chk("f2_bits", bits, mk(16'h1234));
        chk("f2_ur", 64'(ur), 64'd0);

        capture(16'h8000, 1, 16'h0, 0, -1, bits, ur, ov, lat);
        chk("f3_repeat_bits", bits, mk(16'h1234));
        chk("f3_ur", 64'(ur), 64'd1);

        capture(16'h7FFF, 1, 16'h0, 0, -1, bits, ur, ov, lat);
        chk("f4_bits", bits, mk(16'h8000));
        chk("f4_ur", 64'(ur), 64'd0);
        chk("f4_ov", 64'(ov), 64'd0);

        capture(16'h0001, 1, 16'h0002, 1, -1, bits, ur, ov, lat);
        chk("f5_bits", bits, mk(16'h7FFF));
        chk("f5_ur", 64'(ur), 64'd0);
        chk("f5_ov", 64'(ov), 64'd1);

        capture(16'hFFFF, 1, 16'h0, 0, -1, bits, ur, ov, lat);
        chk("f6_bits", bits, mk(16'h0002));
        chk("f6_ov", 64'(ov), 64'd0);

        capture(16'h5555, 1, 16'h0, 0, 1, bits, ur, ov, lat);
        chk("f7_unmuted_bits", bits, mk(16'hFFFF));

        capture(16'hC3C3, 1, 16'h0, 0, 0, bits, ur, ov, lat);
        chk("f8_muted_bits", bits, 64'd0);
        chk("f8_ur", 64'(ur), 64'd0);

        // Reset in the middle of slot 40 while bclk is high and sdata carries a 1.
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!frame_start_out && lat < 2000);
        chk("f9_start", 64'(frame_start_out), 64'd1);
        repeat (162) @(negedge clk);
        chk("pre_rst_sdata", 64'(sdata_out), 64'd1);
        rst_n = 0;
        @(negedge clk);
        chk("mid_rst_bclk",  64'(bclk_out),  64'd0);
        chk("mid_rst_lrclk", 64'(lrclk_out), 64'd1);
        chk("mid_rst_sdata", 64'(sdata_out), 64'd0);
        rst_n = 1;
        edges = 0;
        repeat (600) begin
            @(negedge clk);
            if (bclk_out || frame_start_out || !lrclk_out) edges++;
        end
        chk("idle_quiet", 64'(edges), 64'd0);

        rst_cnt = 0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (rst_cnt > 0) begin
                rst_n = 0;
                rst_cnt--;
            end else begin
                rst_n = 1;
                if ($urandom_range(0, 2999) == 0) rst_cnt = int'($urandom_range(1, 3));
            end
            ready  = ($urandom_range(0, 199) == 0) ||
                     (m_run && (m_t % FRAME == FRAME - 1) && ($urandom_range(0, 1) == 1));
            sample = 16'($urandom);
            if ($urandom_range(0, 399) == 0) mute = ~mute;
        end
        ready = 0;
        rst_n = 1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
